systolic_feeder_32x32: RTL and testbench

Upstream stage of the 32x32 INT8 output-stationary systolic array. Accepts one K-step per beat over a valid/ready stream: an activation column (one element per row) and a weight row (one element per column). Applies the diagonal skew the array needs, drives the array's north/west data and valid lanes, clears its accumulators before each tile, and signals completion once every PE's result is final.

---
 rtl/systolic_feeder_32x32_pkg.sv | 26 ++
 rtl/systolic_feeder_32x32_skew_delay_line.sv | 34 +++
 rtl/systolic_feeder_32x32.sv | 123 ++++++++++++
 tb/tb_systolic_feeder_32x32.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_32x32_pkg.sv
// Shared definitions for the systolic array feeder: default geometry, FSM encoding,
// drain length and lane slicing helper.
package systolic_feeder_32x32_pkg;

  localparam int SIZE_DEFAULT       = 32;
  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int K_WIDTH_DEFAULT    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Lane skew (SIZE-1) + array traversal (SIZE-1) + PE accumulate register (1).
  function automatic int drain_cycles(input int size);
    return 2 * size - 1;
  endfunction

  function automatic int lane_lsb(input int lane, input int data_width);
    return lane * data_width;
  endfunction

endpackage

// File: rtl/systolic_feeder_32x32_skew_delay_line.sv
// Fixed-depth shift register carrying a data word and its valid bit; shifts every cycle.
module skew_delay_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] r_data  [DEPTH];
  logic [DEPTH-1:0]      r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
      r_valid <= '0;
    end else begin
      r_data[0]  <= i_data;
      r_valid[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign o_data  = r_data[DEPTH-1];
  assign o_valid = r_valid[DEPTH-1];

endmodule

// File: rtl/systolic_feeder_32x32.sv
// Feeder for the output-stationary systolic array: accepts K-steps, skews them onto the
// north/west edges, clears accumulators before a tile and pulses done once results are final.
module systolic_feeder_32x32
  import systolic_feeder_32x32_pkg::*;
#(
  parameter int SIZE       = SIZE_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int K_WIDTH    = K_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [K_WIDTH-1:0]         k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIZE*DATA_WIDTH-1:0] in_a,
  input  logic [SIZE*DATA_WIDTH-1:0] in_b,
  output logic [SIZE*DATA_WIDTH-1:0] west_inputs,
  output logic [SIZE-1:0]            west_valid,
  output logic [SIZE*DATA_WIDTH-1:0] north_inputs,
  output logic [SIZE-1:0]            north_valid,
  output logic                       accum_reset,
  output logic                       busy,
  output logic                       done
);

  localparam int              DCW        = $clog2(drain_cycles(SIZE) + 1);
  localparam logic [DCW-1:0]  DRAIN_LOAD = DCW'(drain_cycles(SIZE));

  state_t             r_state, w_state_nxt;
  logic [K_WIDTH-1:0] r_k_rem, w_k_rem_nxt;
  logic [DCW-1:0]     r_drain_cnt, w_drain_cnt_nxt;
  logic               w_accept;

  assign w_accept = in_valid && (r_state == ST_FEED);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_k_rem     <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_k_rem     <= w_k_rem_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_k_rem_nxt     = r_k_rem;
    w_drain_cnt_nxt = r_drain_cnt;
    in_ready        = 1'b0;
    accum_reset     = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = ST_CLEAR;
          w_k_rem_nxt = k_len;
        end
      end
      ST_CLEAR: begin
        accum_reset = 1'b1;
        if (r_k_rem == '0) begin
          w_state_nxt     = ST_DRAIN;
          w_drain_cnt_nxt = DRAIN_LOAD;
        end else begin
          w_state_nxt = ST_FEED;
        end
      end
      ST_FEED: begin
        in_ready = 1'b1;
        if (w_accept && (r_k_rem != '0)) begin
          w_k_rem_nxt = r_k_rem - K_WIDTH'(1);
          if (r_k_rem == K_WIDTH'(1)) begin
            w_state_nxt     = ST_DRAIN;
            w_drain_cnt_nxt = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) w_state_nxt = ST_DONE;
        else                   w_drain_cnt_nxt = r_drain_cnt - DCW'(1);
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Lane i gets i+1 stages so PE (r,c) sees matching K-steps r+c cycles apart from lane 0.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
    localparam int LSB = lane_lsb(gi, DATA_WIDTH);
    logic [DATA_WIDTH-1:0] w_west_d, w_north_d;

    assign w_west_d  = w_accept ? in_a[LSB +: DATA_WIDTH] : '0;
    assign w_north_d = w_accept ? in_b[LSB +: DATA_WIDTH] : '0;

    skew_delay_line #(.DEPTH(gi + 1), .DATA_WIDTH(DATA_WIDTH)) u_west (
      .clk     (clk),
      .rst     (rst),
      .i_data  (w_west_d),
      .i_valid (w_accept),
      .o_data  (west_inputs[LSB +: DATA_WIDTH]),
      .o_valid (west_valid[gi])
    );

    skew_delay_line #(.DEPTH(gi + 1), .DATA_WIDTH(DATA_WIDTH)) u_north (
      .clk     (clk),
      .rst     (rst),
      .i_data  (w_north_d),
      .i_valid (w_accept),
      .o_data  (north_inputs[LSB +: DATA_WIDTH]),
      .o_valid (north_valid[gi])
    );
  end

endmodule

// File: tb/tb_systolic_feeder_32x32.sv
// Self-checking bench for systolic_feeder_32x32 at SIZE=4: per-cycle lane/control model
// plus an array-level matrix product check at each done pulse.
module tb_systolic_feeder_32x32;

  localparam int SIZE = 4;
  localparam int DW   = 8;
  localparam int KW   = 16;
  localparam int MAXC = 4096;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [KW-1:0]      k_len = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [SIZE*DW-1:0] in_a = '0;
  logic [SIZE*DW-1:0] in_b = '0;
  logic [SIZE*DW-1:0] west_inputs, north_inputs;
  logic [SIZE-1:0]    west_valid, north_valid;
  logic               accum_reset, busy, done;

  systolic_feeder_32x32 #(.SIZE(SIZE), .DATA_WIDTH(DW), .K_WIDTH(KW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .k_len        (k_len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .west_inputs  (west_inputs),
    .west_valid   (west_valid),
    .north_inputs (north_inputs),
    .north_valid  (north_valid),
    .accum_reset  (accum_reset),
    .busy         (busy),
    .done         (done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rst = 0;

  logic exp_ready = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_clr = 1'b0;

  // Accepted beats (by the bench's own notion of readiness) and observed edge lanes, per cycle.
  bit                 hist_v [MAXC];
  logic [SIZE*DW-1:0] hist_a [MAXC];
  logic [SIZE*DW-1:0] hist_b [MAXC];
  logic [SIZE*DW-1:0] obs_w  [MAXC];
  logic [SIZE*DW-1:0] obs_n  [MAXC];
  logic [SIZE-1:0]    obs_wv [MAXC];
  logic [SIZE-1:0]    obs_nv [MAXC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [SIZE*DW-1:0] ew, en;
    logic [SIZE-1:0]    ewv, env;
    int j;
    if (cyc < MAXC) begin
      ew = '0; en = '0; ewv = '0; env = '0;
      for (int i = 0; i < SIZE; i++) begin
        j = cyc - 1 - i;
        if (j > last_rst && hist_v[j]) begin
          ewv[i] = 1'b1;
          env[i] = 1'b1;
          ew[i*DW +: DW] = hist_a[j][i*DW +: DW];
          en[i*DW +: DW] = hist_b[j][i*DW +: DW];
        end
      end
      n_cmp++;
      assert (west_inputs === ew) else begin
        n_bad++; $error("FAIL west_data cyc=%0d got=%h exp=%h", cyc, west_inputs, ew);
      end
      n_cmp++;
      assert (west_valid === ewv) else begin
        n_bad++; $error("FAIL west_valid cyc=%0d got=%b exp=%b", cyc, west_valid, ewv);
      end
      n_cmp++;
      assert (north_inputs === en) else begin
        n_bad++; $error("FAIL north_data cyc=%0d got=%h exp=%h", cyc, north_inputs, en);
      end
      n_cmp++;
      assert (north_valid === env) else begin
        n_bad++; $error("FAIL north_valid cyc=%0d got=%b exp=%b", cyc, north_valid, env);
      end
      n_cmp++;
      assert ({in_ready, busy, done, accum_reset} === {exp_ready, exp_busy, exp_done, exp_clr})
      else begin
        n_bad++;
        $error("FAIL ctrl(rdy,busy,done,clr) cyc=%0d got=%b exp=%b", cyc,
               {in_ready, busy, done, accum_reset}, {exp_ready, exp_busy, exp_done, exp_clr});
      end
      hist_v[cyc] = in_valid && exp_ready && !rst;
      hist_a[cyc] = in_a;
      hist_b[cyc] = in_b;
      obs_w[cyc]  = west_inputs;
      obs_n[cyc]  = north_inputs;
      obs_wv[cyc] = west_valid;
      obs_nv[cyc] = north_valid;
      if (rst) last_rst = cyc;
    end else begin
      n_cmp++; n_bad++;
      $fatal(1, "FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic rd, input logic bs, input logic dn, input logic cl);
    exp_ready = rd; exp_busy = bs; exp_done = dn; exp_clr = cl;
  endtask

  task automatic rand_data();
    for (int i = 0; i < SIZE; i++) begin
      in_a[i*DW +: DW] = DW'($urandom);
      in_b[i*DW +: DW] = DW'($urandom);
    end
  endtask

  function automatic int lane_s(input logic [SIZE*DW-1:0] v, input int lane);
    logic signed [DW-1:0] t;
    t = v[lane*DW +: DW];
    return int'(t);
  endfunction

  // mode: 0 random, 1 identity x ramp, 2 single beat {1..4}/{5..8}, 3 expect all-zero
  function automatic int fixed_exp(input int mode, input int r, input int c);
    case (mode)
      1:       return r * SIZE + c + 1;
      2:       return (r + 1) * (5 + c);
      default: return 0;
    endcase
  endfunction

  task automatic check_result(input int c0, input int c1, input int mode);
    int dut_sum, ref_sum, nw, nn;
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        dut_sum = 0; ref_sum = 0;
        for (int n = c0; n <= c1; n++) begin
          if (hist_v[n]) ref_sum += lane_s(hist_a[n], r) * lane_s(hist_b[n], c);
          nw = n - c; nn = n - r;
          if (nw >= c0 && nn >= c0 && obs_wv[nw][r] && obs_nv[nn][c])
            dut_sum += lane_s(obs_w[nw], r) * lane_s(obs_n[nn], c);
        end
        n_cmp++;
        assert (dut_sum === ref_sum) else begin
          n_bad++; $error("FAIL pe_result r=%0d c=%0d got=%0d exp=%0d", r, c, dut_sum, ref_sum);
        end
        if (mode != 0) begin
          n_cmp++;
          assert (dut_sum === fixed_exp(mode, r, c)) else begin
            n_bad++;
            $error("FAIL pe_fixed r=%0d c=%0d got=%0d exp=%0d", r, c, dut_sum, fixed_exp(mode, r, c));
          end
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      next_cycle();
      set_exp(0, 0, 0, 0);
      start = 1'b0;
      in_valid = 1'($urandom);
      rand_data();
    end
  endtask

  // pct < 0 gives the alternating 1,0,1,0,... valid pattern.
  task automatic run_tile(input int k, input int pct, input int mode,
                          input bit start_mid, input int k_bogus);
    int acc, feed_n, c_clear, c_done;
    acc = 0; feed_n = 0;
    next_cycle();
    set_exp(0, 0, 0, 0);
    start = 1'b1; k_len = KW'(k); in_valid = 1'($urandom); rand_data();
    next_cycle();
    set_exp(0, 1, 0, 1);
    c_clear = cyc;
    start = 1'b0; k_len = KW'($urandom); in_valid = 1'($urandom); rand_data();
    while (acc < k) begin
      next_cycle();
      set_exp(1, 1, 0, 0);
      start = start_mid && (feed_n == 0);
      k_len = start ? KW'(k_bogus) : KW'($urandom);
      if (pct < 0) in_valid = (feed_n % 2 == 0);
      else         in_valid = ($urandom_range(99) < pct) || (feed_n >= 50);
      rand_data();
      if (in_valid) begin
        for (int i = 0; i < SIZE; i++) begin
          if (mode == 1) begin
            in_a[i*DW +: DW] = (i == acc) ? DW'(1) : DW'(0);
            in_b[i*DW +: DW] = DW'(acc * SIZE + i + 1);
          end else if (mode == 2) begin
            in_a[i*DW +: DW] = DW'(i + 1);
            in_b[i*DW +: DW] = DW'(5 + i);
          end
        end
        acc++;
      end
      feed_n++;
    end
    repeat (2 * SIZE) begin
      next_cycle();
      set_exp(0, 1, 0, 0);
      start = 1'($urandom); k_len = KW'($urandom); in_valid = 1'($urandom); rand_data();
    end
    next_cycle();
    set_exp(0, 1, 1, 0);
    c_done = cyc;
    start = 1'($urandom); in_valid = 1'($urandom); rand_data();
    next_cycle();
    set_exp(0, 0, 0, 0);
    start = 1'b0; in_valid = 1'b0;
    check_result(c_clear, c_done, mode);
  endtask

  initial begin
    rand_data();
    repeat (3) next_cycle();
    rst = 1'b0;
    idle_cycles(6);

    run_tile(1, 100, 2, 1'b0, 0);
    idle_cycles(2);
    run_tile(4, 100, 1, 1'b0, 0);
    idle_cycles(1);
    run_tile(3, -1, 0, 1'b0, 0);
    run_tile(0, 100, 3, 1'b0, 0);
    idle_cycles(3);
    run_tile(3, 100, 0, 1'b1, 7);

    // Reset mid-FEED: tile is abandoned, chains flushed, no done.
    next_cycle();
    set_exp(0, 0, 0, 0);
    start = 1'b1; k_len = KW'(6); in_valid = 1'b0; rand_data();
    next_cycle();
    set_exp(0, 1, 0, 1);
    start = 1'b0;
    repeat (2) begin
      next_cycle();
      set_exp(1, 1, 0, 0);
      in_valid = 1'b1; rand_data();
    end
    next_cycle();
    set_exp(1, 1, 0, 0);
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) begin
      next_cycle();
      set_exp(0, 0, 0, 0);
      in_valid = 1'($urandom); start = 1'($urandom);
    end
    next_cycle();
    set_exp(0, 0, 0, 0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    idle_cycles(2);
    run_tile(4, 100, 1, 1'b0, 0);

    repeat (6) begin
      idle_cycles($urandom_range(0, 3));
      run_tile($urandom_range(1, 9), $urandom_range(30, 100), 0, 1'($urandom), $urandom_range(1, 20));
    end
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
